// File: rtl/csr_pkg.sv
// Shared types and constants for the serialising CSR execution unit.
package csr_pkg;

    typedef enum logic [2:0] {
        OP_CSRRW  = 3'd0,
        OP_CSRRS  = 3'd1,
        OP_CSRRC  = 3'd2,
        OP_CSRRWI = 3'd3,
        OP_CSRRSI = 3'd4,
        OP_CSRRCI = 3'd5,
        OP_ECALL  = 3'd6,
        OP_MRET   = 3'd7
    } csr_op_e;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    localparam int WEN_MEPC    = 0;
    localparam int WEN_MCAUSE  = 1;
    localparam int WEN_MSTATUS = 2;
    localparam int WEN_MTVEC   = 3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_READ, ST_WRITE, ST_RESP, ST_TRAP, ST_REDIR
    } state_e;

    // Request fields held for the READ cycle.
    typedef struct packed {
        csr_op_e     op;
        logic [11:0] addr;
        logic [4:0]  zimm;
        logic        src_zero;
    } csr_req_t;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational CSR decode, read mux and read-modify-write value generation.
module csr_rmw_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  csr_op_e          op,
    input  logic [11:0]      addr,
    input  logic [XLEN-1:0]  rs1,
    input  logic [4:0]       zimm,
    input  logic             src_zero,
    input  logic [31:0]      mstatus_i,
    input  logic [31:0]      mtvec_i,
    input  logic [31:0]      mepc_i,
    input  logic [31:0]      mcause_i,
    input  logic [31:0]      mvendorid_i,
    input  logic [31:0]      marchid_i,
    output logic [31:0]      rdata,
    output logic [31:0]      wdata,
    output logic [3:0]       wen,
    output logic             illegal,
    output logic             do_write
);

    logic        known;
    logic        read_only;
    logic        want_write;
    logic [3:0]  sel;
    logic [31:0] src;

    always_comb begin
        rdata     = '0;
        known     = 1'b1;
        read_only = 1'b0;
        sel       = '0;
        case (addr)
            ADDR_MSTATUS:   begin rdata = mstatus_i; sel[WEN_MSTATUS] = 1'b1; end
            ADDR_MTVEC:     begin rdata = mtvec_i;   sel[WEN_MTVEC]   = 1'b1; end
            ADDR_MEPC:      begin rdata = mepc_i;    sel[WEN_MEPC]    = 1'b1; end
            ADDR_MCAUSE:    begin rdata = mcause_i;  sel[WEN_MCAUSE]  = 1'b1; end
            ADDR_MVENDORID: begin rdata = mvendorid_i; read_only = 1'b1; end
            ADDR_MARCHID:   begin rdata = marchid_i;   read_only = 1'b1; end
            default:        known = 1'b0;
        endcase
    end

    always_comb begin
        src = (op inside {OP_CSRRW, OP_CSRRS, OP_CSRRC}) ? rs1[31:0] : {27'b0, zimm};
        case (op)
            OP_CSRRW, OP_CSRRWI: begin wdata = src;           want_write = 1'b1;      end
            OP_CSRRS, OP_CSRRSI: begin wdata = rdata | src;   want_write = !src_zero; end
            OP_CSRRC, OP_CSRRCI: begin wdata = rdata & ~src;  want_write = !src_zero; end
            default:             begin wdata = rdata;         want_write = 1'b0;      end
        endcase
    end

    // A set/clear with a zero source is a pure read, so it may target read-only CSRs.
    assign illegal  = !known || (want_write && read_only);
    assign do_write = want_write && !illegal;
    assign wen      = do_write ? sel : 4'b0;

endmodule

// File: rtl/csr_exec_unit.sv
// Serialising issue unit for CSR ops, ECALL and MRET; one operation in flight.
module csr_exec_unit
    import csr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [11:0]       in_addr,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [4:0]        in_zimm,
    input  logic              in_src_zero,
    input  logic [31:0]       in_pc,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    input  logic [31:0]       mstatus_i,
    input  logic [31:0]       mtvec_i,
    input  logic [31:0]       mepc_i,
    input  logic [31:0]       mcause_i,
    input  logic [31:0]       mvendorid_i,
    input  logic [31:0]       marchid_i,
    output logic [31:0]       csrd,
    output logic [3:0]        csr_wen,
    output logic              ecall_flag,
    output logic [31:0]       pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);

    state_e            state;
    csr_req_t          req;
    logic [XLEN-1:0]   rs1_q;
    logic [TAG_W-1:0]  tag_q;
    logic              resp_q;
    logic              redir_q;

    logic [31:0]       alu_rdata;
    logic [31:0]       alu_wdata;
    logic [3:0]        alu_wen;
    logic              alu_illegal;
    logic              alu_do_write;

    csr_rmw_alu #(.XLEN(XLEN)) u_alu (
        .op          (req.op),
        .addr        (req.addr),
        .rs1         (rs1_q),
        .zimm        (req.zimm),
        .src_zero    (req.src_zero),
        .mstatus_i   (mstatus_i),
        .mtvec_i     (mtvec_i),
        .mepc_i      (mepc_i),
        .mcause_i    (mcause_i),
        .mvendorid_i (mvendorid_i),
        .marchid_i   (marchid_i),
        .rdata       (alu_rdata),
        .wdata       (alu_wdata),
        .wen         (alu_wen),
        .illegal     (alu_illegal),
        .do_write    (alu_do_write)
    );

    assign in_ready = (state == ST_IDLE);
    // A flush suppresses the response/redirect in the very cycle it arrives.
    assign out_valid      = resp_q & ~flush;
    assign redirect_valid = redir_q & ~flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            req         <= '0;
            rs1_q       <= '0;
            tag_q       <= '0;
            csrd        <= '0;
            csr_wen     <= '0;
            ecall_flag  <= 1'b0;
            pc          <= '0;
            resp_q      <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
            redir_q     <= 1'b0;
            redirect_pc <= '0;
        end else begin
            csr_wen    <= '0;
            ecall_flag <= 1'b0;
            redir_q    <= 1'b0;
            case (state)
                ST_IDLE: if (in_valid && !flush) begin
                    req   <= '{op: csr_op_e'(in_op), addr: in_addr,
                               zimm: in_zimm, src_zero: in_src_zero};
                    rs1_q <= in_rs1;
                    tag_q <= in_tag;
                    case (csr_op_e'(in_op))
                        OP_ECALL: begin
                            state      <= ST_TRAP;
                            ecall_flag <= 1'b1;
                            pc         <= in_pc;
                        end
                        OP_MRET: begin
                            state       <= ST_REDIR;
                            redir_q     <= 1'b1;
                            redirect_pc <= mepc_i;
                        end
                        default: state <= ST_READ;
                    endcase
                end
                ST_READ: begin
                    // Response fields are captured now; they stay put through WRITE.
                    out_data    <= alu_illegal ? '0 : XLEN'(alu_rdata);
                    out_illegal <= alu_illegal;
                    out_tag     <= tag_q;
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (alu_do_write) begin
                        state   <= ST_WRITE;
                        csr_wen <= alu_wen;
                        csrd    <= alu_wdata;
                    end else begin
                        state  <= ST_RESP;
                        resp_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state  <= flush ? ST_IDLE : ST_RESP;
                    resp_q <= !flush;
                end
                ST_TRAP: begin
                    state       <= flush ? ST_IDLE : ST_REDIR;
                    redir_q     <= !flush;
                    redirect_pc <= mtvec_i & ~32'h3;
                end
                ST_REDIR: state <= ST_IDLE;
                ST_RESP: if (flush || out_ready) begin
                    state  <= ST_IDLE;
                    resp_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
